// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHK, S_RUN, S_ERR
  } state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  // Clock cycles per UART bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte strobe.
module uart_rx_byte #(
  parameter int DIV = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_ferr
);

  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  rx_state_t     r_state;
  logic          r_s1, r_s2, r_s3;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1       <= 1'b1;
      r_s2       <= 1'b1;
      r_s3       <= 1'b1;
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_sh       <= '0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
      o_rx_ferr  <= 1'b0;
    end else begin
      r_s1       <= i_rx;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      o_rx_valid <= 1'b0;
      case (r_state)
        RX_IDLE: if (r_s3 && !r_s2) begin
          r_state <= RX_START;
          r_cnt   <= '0;
        end
        // Start bit re-checked half a bit in; a high line means a glitch.
        RX_START: if (r_cnt == HALF) begin
          r_cnt <= '0;
          r_bit <= '0;
          r_state <= r_s2 ? RX_IDLE : RX_BITS;
        end else r_cnt <= r_cnt + 1'b1;
        RX_BITS: if (r_cnt == FULL) begin
          r_cnt <= '0;
          r_sh  <= {r_s2, r_sh[7:1]};
          r_bit <= r_bit + 1'b1;
          if (r_bit == 3'd7) r_state <= RX_STOP;
        end else r_cnt <= r_cnt + 1'b1;
        RX_STOP: if (r_cnt == FULL) begin
          o_rx_valid <= 1'b1;
          o_rx_data  <= r_sh;
          o_rx_ferr  <= !r_s2;
          r_state    <= RX_IDLE;
        end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// UART boot loader: writes a length-prefixed image into instruction memory, then releases the core.
// Optional trailing checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 10
) (
  input  logic              CLOCK,
  input  logic              RST,
  input  logic              uart_rx,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  logic       w_rx_valid, w_rx_ferr, w_fail;
  logic [7:0] w_rx_data;
  logic [15:0] w_len;
  logic [ADDR_W:0] w_cnt_nxt;

  state_t            r_state;
  logic              r_we, r_hold, r_busy, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_word;
  logic [7:0]        r_nlo;
  logic [ADDR_W:0]   r_n, r_cnt;
  logic [1:0]        r_bidx;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
`endif

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .i_clk      (CLOCK),
    .i_rst      (RST),
    .i_rx       (uart_rx),
    .o_rx_valid (w_rx_valid),
    .o_rx_data  (w_rx_data),
    .o_rx_ferr  (w_rx_ferr)
  );

  assign w_len     = {w_rx_data, r_nlo};
  assign w_cnt_nxt = r_cnt + 1'b1;

  // Every path into ERR is decided here so the FSM has one abort branch.
  always_comb begin
    w_fail = 1'b0;
    if (w_rx_valid) begin
      case (r_state)
        S_LEN0, S_DATA: w_fail = w_rx_ferr;
        S_LEN1: w_fail = w_rx_ferr || (w_len == 16'd0) || ({1'b0, w_len} > CAP);
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK:  w_fail = w_rx_ferr || (w_rx_data != r_sum);
`endif
        default: w_fail = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_state <= S_LEN0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_nlo   <= '0;
      r_n     <= '0;
      r_cnt   <= '0;
      r_bidx  <= '0;
      r_word  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      if (w_fail) begin
        r_state <= S_ERR;
        r_err   <= 1'b1;
        r_hold  <= 1'b1;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_LEN0: if (w_rx_valid) begin
            r_nlo   <= w_rx_data;
            r_busy  <= 1'b1;
            r_state <= S_LEN1;
          end
          S_LEN1: if (w_rx_valid) begin
            r_n     <= w_len[ADDR_W:0];
            r_cnt   <= '0;
            r_bidx  <= '0;
            r_state <= S_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
          end
          // Bytes shift in from the top, so byte 0 lands in [7:0] after four.
          S_DATA: if (w_rx_valid) begin
            r_word <= {w_rx_data, r_word[31:8]};
            r_bidx <= r_bidx + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum  <= r_sum + w_rx_data;
`endif
            if (r_bidx == 2'd3) begin
              r_state <= S_WRITE;
              r_we    <= 1'b1;
              r_addr  <= r_cnt[ADDR_W-1:0];
              r_wdata <= {w_rx_data, r_word[31:8]};
            end
          end
          S_WRITE: begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_n) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_RUN;
              r_hold  <= 1'b0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
`endif
            end else r_state <= S_DATA;
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          S_CHK: if (w_rx_valid) begin
            r_state <= S_RUN;
            r_hold  <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
`endif
          S_RUN, S_ERR: if (start) begin
            r_state <= S_LEN0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
          end
          default: r_state <= S_ERR;
        endcase
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_hold  = r_hold;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed loads plus random images checked against a byte-list model.
module tb_prog_loader;

  typedef logic [7:0] u8_t;

  logic        CLOCK = 1'b0, RST = 1'b1, uart_rx = 1'b1, start = 1'b0;
  logic        imem_we, core_hold, busy, done, err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;

  prog_loader #(.CLK_FREQ(1000000), .BAUD(125000), .ADDR_W(10)) dut (
    .CLOCK(CLOCK), .RST(RST), .uart_rx(uart_rx), .start(start),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 CLOCK = ~CLOCK;

  int          n_chk = 0, n_fail = 0;
  u8_t         tx_q[$];
  logic [41:0] obs_w[$], exp_w[$];
  logic [1:0]  post_q[$];
  bit          we_d = 1'b0;
  int          m_state, m_n;   // m_state: 0 running, 1 error, 2 still loading

  // Write log, plus {core_hold,done} one cycle after each write strobe.
  always @(negedge CLOCK) begin
    if (we_d) post_q.push_back({core_hold, done});
    we_d = imem_we;
    if (imem_we) obs_w.push_back({imem_addr, imem_wdata});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK); #1;
  endtask

  task automatic send_byte(input u8_t b, input bit stop_ok);
    uart_rx = 1'b0; repeat (8) tick;
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (8) tick; end
    uart_rx = stop_ok; repeat (8) tick;
    uart_rx = 1'b1; repeat (16) tick;
  endtask

  task automatic append_sum;
    u8_t s = 8'h00;
    for (int i = 2; i < tx_q.size(); i++) s += tx_q[i];
    tx_q.push_back(s);
  endtask

  // Expected outcome of tx_q derived only from the protocol rules.
  task automatic model;
    int nb;
    u8_t s;
    exp_w.delete();
    m_n = int'({tx_q[1], tx_q[0]});
    if (m_n == 0 || m_n > 1024) begin m_state = 1; return; end
    nb = tx_q.size() - 2;
    for (int i = 0; i < m_n && 4 * i + 4 <= nb; i++)
      exp_w.push_back({10'(i), tx_q[2+4*i+3], tx_q[2+4*i+2], tx_q[2+4*i+1], tx_q[2+4*i]});
    if (nb < 4 * m_n) m_state = 2;
`ifdef PROG_LOADER_CHECKSUM_EN
    else if (nb == 4 * m_n) m_state = 2;
    else begin
      s = 8'h00;
      for (int i = 0; i < 4 * m_n; i++) s += tx_q[2+i];
      m_state = (s == tx_q[2+4*m_n]) ? 0 : 1;
    end
`else
    else m_state = 0;
`endif
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_nwr"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
      chk({tag, "_wr"}, obs_w[i], exp_w[i]);
    chk({tag, "_done"}, done, m_state == 0);
    chk({tag, "_err"}, err, m_state == 1);
    chk({tag, "_hold"}, core_hold, m_state != 0);
    chk({tag, "_busy"}, busy, m_state == 2);
    if (exp_w.size() == m_n && post_q.size() > 0)
`ifdef PROG_LOADER_CHECKSUM_EN
      chk({tag, "_post"}, post_q[post_q.size()-1], 2'b10);
`else
      chk({tag, "_post"}, post_q[post_q.size()-1], 2'b01);
`endif
  endtask

  task automatic run_load(input string tag);
    model;
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
    repeat (20) tick;
    check_result(tag);
  endtask

  task automatic restart;
    tick;
    start = 1'b1; tick; start = 1'b0;
    chk("rst_hold", core_hold, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    obs_w.delete(); post_q.delete();
  endtask

  initial begin
    int n;
    RST = 1'b1; repeat (2) tick;
    chk("r_hold", core_hold, 1'b1); chk("r_we", imem_we, 1'b0);
    chk("r_addr", imem_addr, 10'd0); chk("r_wdata", imem_wdata, 32'd0);
    chk("r_busy", busy, 1'b0); chk("r_done", done, 1'b0); chk("r_err", err, 1'b0);
    RST = 1'b0;
    repeat (1000) tick;
    chk("idle_nwr", obs_w.size(), 0);
    chk("idle_busy", busy, 1'b0);

    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef PROG_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h4B);
`endif
    run_load("two");
    if (obs_w.size() == 2) begin
      chk("two_w0", obs_w[0], {10'd0, 32'h00000013});
      chk("two_w1", obs_w[1], {10'd1, 32'hDEADBEEF});
    end
    chk("two_run", {core_hold, done}, 2'b01);
`ifdef PROG_LOADER_CHECKSUM_EN
    restart;
    tx_q[tx_q.size()-1] = 8'h4C;
    run_load("badsum");
    chk("badsum_err", {err, core_hold}, 2'b11);
`endif
    restart;

    tx_q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef PROG_LOADER_CHECKSUM_EN
    append_sum;
`endif
    run_load("reload");
    if (obs_w.size() == 1) chk("reload_w0", obs_w[0], {10'd0, 32'h12345678});
    restart;

    tx_q = '{8'h00, 8'h00};
    run_load("n0");
    restart;
    tx_q = '{8'h01, 8'h04};
    run_load("n1025");
    restart;

    foreach (tx_q[i]) ;
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00};
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (20) tick;
    chk("ferr_err", err, 1'b1);
    chk("ferr_nwr", obs_w.size(), 0);
    chk("ferr_busy", busy, 1'b0);
    restart;

    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 4);
      if (k % 4 == 3) n = (k == 3) ? 0 : 1025 + $urandom_range(0, 100);
      tx_q = '{8'(n), 8'(n >> 8)};
      if (n >= 1 && n <= 1024) begin
        for (int i = 0; i < 4 * n; i++) tx_q.push_back(8'($urandom));
`ifdef PROG_LOADER_CHECKSUM_EN
        append_sum;
        if ($urandom_range(0, 3) == 0) tx_q[tx_q.size()-1] = tx_q[tx_q.size()-1] ^ 8'h01;
`endif
      end else begin
        for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
      end
      run_load("rnd");
      restart;
    end

    tx_q = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
    chk("mid_nwr", obs_w.size(), 1);
    if (obs_w.size() > 0) chk("mid_w0", obs_w[0], {10'd0, 32'h44332211});
    RST = 1'b1; repeat (2) tick;
    chk("mid_hold", core_hold, 1'b1); chk("mid_we", imem_we, 1'b0);
    chk("mid_addr", imem_addr, 10'd0); chk("mid_wdata", imem_wdata, 32'd0);
    chk("mid_bde", {busy, done, err}, 3'b000);
    RST = 1'b0;
    obs_w.delete(); post_q.delete();
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef PROG_LOADER_CHECKSUM_EN
    append_sum;
`endif
    run_load("fresh");
    if (obs_w.size() == 1) chk("fresh_w0", obs_w[0], {10'd0, 32'hDDCCBBAA});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
